// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: fetch, load/store and memory handshake bundle; slave = arbiter side, master = requesters and memory
interface unified_mem_arbiter_if #(
  parameter int N = 32
);
  logic         if_req;
  logic [N-1:0] if_addr;
  logic [N-1:0] if_rdata;
  logic         if_valid;
  logic         d_req;
  logic         d_we;
  logic [N-1:0] d_addr;
  logic [N-1:0] d_wdata;
  logic [1:0]   d_size;
  logic [N-1:0] d_rdata;
  logic         d_valid;
  logic         mem_req;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [1:0]   mem_size;
  logic [N-1:0] mem_rdata;
  logic         mem_ready;
  logic         stall;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    output if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_size, stall
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata, mem_ready,
    input  if_rdata, if_valid, d_rdata, d_valid, mem_req, mem_we, mem_addr, mem_wdata, mem_size, stall
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between fetch and load/store with a data-burst cap, variable latency and stall
module unified_mem_arbiter #(
  parameter int N = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input logic clk,
  input logic rst,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
  state_t       r_state;
  state_t       w_next;
  logic [3:0]   r_burst_cnt;
  logic         w_burst_full;
  logic         w_grant_d;
  logic         w_grant_f;
  logic         w_done;
  logic [N-1:0] w_rdata;
  always_comb begin
    w_burst_full = r_burst_cnt == 4'(MAX_DATA_BURST);
    w_grant_d = r_state == IDLE && bus.d_req && !(bus.if_req && w_burst_full);
    w_grant_f = r_state == IDLE && bus.if_req && !w_grant_d;
    w_done = r_state != IDLE && bus.mem_ready;
    w_rdata = bus.mem_rdata;
    w_next = w_grant_d ? DATA : w_grant_f ? FETCH : w_done ? IDLE : r_state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_req <= 1'b0;
      bus.mem_we <= 1'b0;
      bus.mem_addr <= '0;
      bus.mem_wdata <= '0;
      bus.mem_size <= 2'b00;
      bus.if_rdata <= '0;
      bus.d_rdata <= '0;
      bus.if_valid <= 1'b0;
      bus.d_valid <= 1'b0;
      r_burst_cnt <= 4'd0;
    end else begin
      bus.if_valid <= w_done && r_state == FETCH;
      bus.d_valid <= w_done && r_state == DATA;
      if (w_done && r_state == FETCH) bus.if_rdata <= w_rdata;
      if (w_done && r_state == DATA && !bus.mem_we) bus.d_rdata <= w_rdata;
      if (w_done) begin
        bus.mem_req <= 1'b0;
        bus.mem_we <= 1'b0;
      end
      if (w_grant_f) begin
        bus.mem_req <= 1'b1;
        bus.mem_we <= 1'b0;
        bus.mem_addr <= bus.if_addr;
        bus.mem_size <= 2'b10;
        r_burst_cnt <= 4'd0;
      end
      if (w_grant_d) begin
        bus.mem_req <= 1'b1;
        bus.mem_we <= bus.d_we;
        bus.mem_addr <= bus.d_addr;
        bus.mem_wdata <= bus.d_wdata;
        bus.mem_size <= bus.d_size == 2'b11 ? 2'b10 : bus.d_size;
        r_burst_cnt <= !bus.if_req ? 4'd0 : w_burst_full ? r_burst_cnt : r_burst_cnt + 4'd1;
      end
    end
  end
  assign bus.stall = (bus.if_req & ~bus.if_valid) | (bus.d_req & ~bus.d_valid);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: vector table, directed corner sequences and a randomized run against a transaction-level model
module tb_unified_mem_arbiter;
  localparam int N = 32;
  localparam int MAXB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  unified_mem_arbiter_if #(.N(N)) bus ();
  unified_mem_arbiter #(.N(N), .MAX_DATA_BURST(MAXB)) dut (.clk(clk), .rst(rst), .bus(bus));
  int passed = 0;
  int total = 0;
  logic [31:0] exp_d = 32'h0;
  logic [31:0] last_wdata = 32'h0;
  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic [1:0]  exp_size;
    logic [31:0] rdata;
    int          lat;
  } vec_t;
  vec_t vecs[6];
  logic        busy, who_d, acc_we, e_req, e_we, e_if_valid, e_d_valid;
  logic [31:0] e_addr, e_wdata, e_if_rdata, e_d_rdata;
  logic [1:0]  e_size;
  int          burst;
  logic        p_if_req, p_d_req, p_d_we, p_ready;
  logic [31:0] p_if_addr, p_d_addr, p_d_wdata, p_rdata;
  logic [1:0]  p_d_size;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic clear_inputs();
    bus.if_req = 1'b0;
    bus.if_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    bus.d_size = 2'b00;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask
  task automatic do_access(input vec_t v);
    if (v.is_d) begin
      bus.d_req = 1'b1;
      bus.d_we = v.we;
      bus.d_addr = v.addr;
      bus.d_wdata = v.wdata;
      bus.d_size = v.size;
    end else begin
      bus.if_req = 1'b1;
      bus.if_addr = v.addr;
    end
    #1 chk("stall_on_req", 32'(bus.stall), 1);
    @(negedge clk);
    chk("grant_req", 32'(bus.mem_req), 1);
    chk("grant_addr", bus.mem_addr, v.addr);
    chk("grant_we", 32'(bus.mem_we), 32'(v.is_d & v.we));
    chk("grant_size", 32'(bus.mem_size), 32'(v.exp_size));
    if (v.is_d) last_wdata = v.wdata;
    chk("grant_wdata", bus.mem_wdata, last_wdata);
    for (int i = 1; i <= v.lat; i++) begin
      bus.mem_ready = (i == v.lat);
      bus.mem_rdata = (i == v.lat) ? v.rdata : 32'hDEAD0000;
      chk("busy_stall", 32'(bus.stall), 1);
      chk("busy_no_valid", 32'({bus.if_valid, bus.d_valid}), 0);
      @(negedge clk);
    end
    bus.mem_ready = 1'b0;
    chk("valid_pulse", 32'({bus.if_valid, bus.d_valid}), v.is_d ? 1 : 2);
    chk("done_req_low", 32'(bus.mem_req), 0);
    chk("valid_stall_low", 32'(bus.stall), 0);
    if (!v.is_d) chk("if_rdata", bus.if_rdata, v.rdata);
    else begin
      if (!v.we) exp_d = v.rdata;
      chk("d_rdata", bus.d_rdata, exp_d);
    end
    bus.if_req = 1'b0;
    bus.d_req = 1'b0;
    @(negedge clk);
    chk("valid_one_cycle", 32'({bus.if_valid, bus.d_valid}), 0);
  endtask
  task automatic model_edge();
    e_if_valid = 1'b0;
    e_d_valid = 1'b0;
    if (busy) begin
      if (p_ready) begin
        busy = 1'b0;
        e_req = 1'b0;
        e_we = 1'b0;
        if (who_d) begin
          e_d_valid = 1'b1;
          if (!acc_we) e_d_rdata = p_rdata;
        end else begin
          e_if_valid = 1'b1;
          e_if_rdata = p_rdata;
        end
      end
    end else if (p_if_req || p_d_req) begin
      who_d = p_d_req && !(p_if_req && burst == MAXB);
      busy = 1'b1;
      e_req = 1'b1;
      if (who_d) begin
        burst = p_if_req ? (burst < MAXB ? burst + 1 : burst) : 0;
        e_we = p_d_we;
        acc_we = p_d_we;
        e_addr = p_d_addr;
        e_wdata = p_d_wdata;
        e_size = p_d_size == 2'b11 ? 2'b10 : p_d_size;
      end else begin
        burst = 0;
        e_we = 1'b0;
        e_addr = p_if_addr;
        e_size = 2'b10;
      end
    end
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    vecs[0] = '{1'b0, 1'b0, 32'h10, 32'h0, 2'b10, 2'b10, 32'h00A00093, 3};
    vecs[1] = '{1'b1, 1'b0, 32'h100, 32'h11111111, 2'b10, 2'b10, 32'h12345678, 1};
    vecs[2] = '{1'b1, 1'b1, 32'h202, 32'h0000BEEF, 2'b01, 2'b01, 32'h99999999, 2};
    vecs[3] = '{1'b1, 1'b1, 32'h304, 32'hCAFEF00D, 2'b11, 2'b10, 32'h77777777, 1};
    vecs[4] = '{1'b1, 1'b0, 32'h7, 32'h0, 2'b00, 2'b00, 32'h000000FF, 4};
    vecs[5] = '{1'b0, 1'b0, 32'h14, 32'h0, 2'b10, 2'b10, 32'h00100113, 1};
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_mem_size", 32'(bus.mem_size), 0);
    chk("rst_valids", 32'({bus.if_valid, bus.d_valid}), 0);
    chk("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
    rst = 1'b0;
    bus.if_req = 1'b1;
    bus.if_addr = 32'h40;
    @(negedge clk);
    chk("rst_mid_fetch_req", 32'(bus.mem_req), 1);
    #2 rst = 1'b1;
    #1 chk("rst_async_drop", 32'(bus.mem_req), 0);
    bus.if_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_stray_ready", 32'({bus.mem_req, bus.if_valid, bus.d_valid}), 0);
    end
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) do_access(vecs[i]);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h20;
    bus.d_req = 1'b1;
    bus.d_we = 1'b0;
    bus.d_addr = 32'h100;
    bus.d_size = 2'b10;
    bus.d_wdata = 32'h55;
    @(negedge clk);
    chk("cont_data_first", bus.mem_addr, 32'h100);
    chk("cont_burst_1", 32'(dut.r_burst_cnt), 1);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hA5A5A5A5;
    @(negedge clk);
    chk("cont_d_valid", 32'({bus.if_valid, bus.d_valid}), 1);
    chk("cont_d_rdata", bus.d_rdata, 32'hA5A5A5A5);
    chk("cont_bubble", 32'(bus.mem_req), 0);
    exp_d = 32'hA5A5A5A5;
    bus.d_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    chk("cont_fetch_req", 32'(bus.mem_req), 1);
    chk("cont_fetch_addr", bus.mem_addr, 32'h20);
    chk("cont_burst_0", 32'(dut.r_burst_cnt), 0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h00000013;
    @(negedge clk);
    chk("cont_if_valid", 32'({bus.if_valid, bus.d_valid}), 2);
    chk("cont_if_rdata", bus.if_rdata, 32'h13);
    bus.if_req = 1'b0;
    bus.mem_ready = 1'b0;
    @(negedge clk);
    bus.if_req = 1'b1;
    bus.if_addr = 32'h30;
    bus.d_req = 1'b1;
    bus.d_addr = 32'h400;
    bus.mem_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 60 && n < 2 * (MAXB + 1); c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        chk("starve_grant_is_fetch", 32'(bus.mem_addr == 32'h30), 32'((n % (MAXB + 1)) == MAXB));
        n++;
      end
    end
    chk("starve_grant_count", n, 2 * (MAXB + 1));
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    {busy, who_d, acc_we, e_req, e_we, e_if_valid, e_d_valid} = '0;
    {e_addr, e_wdata, e_if_rdata, e_d_rdata} = '0;
    e_size = 2'b00;
    burst = 0;
    {p_if_req, p_d_req, p_d_we, p_ready} = '0;
    {p_if_addr, p_d_addr, p_d_wdata, p_rdata} = '0;
    p_d_size = 2'b00;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      model_edge();
      chk("rnd_mem_req", 32'(bus.mem_req), 32'(e_req));
      chk("rnd_mem_we", 32'(bus.mem_we), 32'(e_we));
      chk("rnd_mem_addr", bus.mem_addr, e_addr);
      chk("rnd_mem_wdata", bus.mem_wdata, e_wdata);
      chk("rnd_mem_size", 32'(bus.mem_size), 32'(e_size));
      chk("rnd_valids", 32'({bus.if_valid, bus.d_valid}), 32'({e_if_valid, e_d_valid}));
      chk("rnd_if_rdata", bus.if_rdata, e_if_rdata);
      chk("rnd_d_rdata", bus.d_rdata, e_d_rdata);
      if (!bus.if_req || e_if_valid) begin
        bus.if_req = ($urandom % 3) == 0;
        bus.if_addr = $urandom & 32'hFFFC;
      end else if (!(busy && !who_d) && ($urandom % 4) == 0) bus.if_addr = $urandom & 32'hFFFC;
      if (!bus.d_req || e_d_valid) begin
        bus.d_req = ($urandom % 2) == 0;
        bus.d_we = $urandom % 2;
        bus.d_addr = $urandom;
        bus.d_wdata = $urandom;
        bus.d_size = 2'($urandom % 4);
      end else if (!(busy && who_d) && ($urandom % 4) == 0) bus.d_addr = $urandom;
      bus.mem_ready = ($urandom % 3) == 0;
      bus.mem_rdata = $urandom;
      p_if_req = bus.if_req;
      p_if_addr = bus.if_addr;
      p_d_req = bus.d_req;
      p_d_we = bus.d_we;
      p_d_addr = bus.d_addr;
      p_d_wdata = bus.d_wdata;
      p_d_size = bus.d_size;
      p_ready = bus.mem_ready;
      p_rdata = bus.mem_rdata;
      #1 chk("rnd_stall", 32'(bus.stall), 32'((bus.if_req & ~e_if_valid) | (bus.d_req & ~e_d_valid)));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Arbitrates one single-ported unified instruction/data memory between two requesters: the fetch stage and the load/store (MEM) stage.
- Sequences each access through a small FSM and handles variable memory latency via mem_ready.
- Returns read data to the requester and drives a pipeline stall line.
- Sits between the PC/fetch logic, the MEM stage and the memory model; the store width comes from the control unit's SaveMethod encoding.

Parameters:
- N, 32, data and address width.
- MAX_DATA_BURST, 4, max consecutive data grants while a fetch is waiting (range 1-15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  fetch request, held until if_valid.
- if_addr  in  N  fetch address (PC).
- if_rdata  out  N  fetched instruction.
- if_valid  out  1  one-cycle pulse: if_rdata valid.
- d_req  in  1  data request, held until d_valid.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  N  data address.
- d_wdata  in  N  store data.
- d_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- d_rdata  out  N  load data.
- d_valid  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  N  memory address.
- mem_wdata  out  N  memory write data.
- mem_size  out  2  access size, same encoding as d_size.
- mem_rdata  in  N  memory read data, valid with mem_ready.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  out  1  pipeline stall.

Behaviour:
- Clock and reset: one clock clk; rst is asynchronous, active-high.
- Reset values: FSM=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_size=00; if_rdata=0, d_rdata=0; if_valid=0, d_valid=0; burst_cnt=0.
- States:
  - IDLE: arbitrate.
  - FETCH: fetch access in flight.
  - DATA: data access in flight.
- Arbitration, evaluated at each clk edge in IDLE only:
  - No request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: data wins unless burst_cnt==MAX_DATA_BURST, in which case fetch wins.
- burst_cnt:
  - Increments on a data grant made while if_req=1.
  - Clears on any fetch grant, and on any data grant while if_req=0.
  - Saturates at MAX_DATA_BURST.
- Grant edge, all mem_* registered:
  - Fetch grant: mem_req=1, mem_we=0, mem_addr=if_addr, mem_size=10, mem_wdata unchanged.
  - Data grant: mem_req=1, mem_we=d_we, mem_addr=d_addr, mem_wdata=d_wdata, mem_size=d_size (11 mapped to 10).
  - mem_* hold stable until completion.
- Completion: in FETCH/DATA, mem_ready=1 at an edge:
  - mem_req and mem_we cleared.
  - FSM returns to IDLE.
  - FETCH: if_rdata<=mem_rdata, if_valid=1 for exactly the next cycle.
  - DATA load: d_rdata<=mem_rdata, d_valid=1 for exactly the next cycle.
  - DATA store: d_rdata unchanged, d_valid=1 for exactly the next cycle.
- Minimum access: grant edge, one busy cycle, mem_ready, valid cycle. A one-cycle bubble (IDLE) always separates consecutive accesses. The requester drops or replaces its req in the valid cycle, so no duplicate grant occurs.
- mem_ready while in IDLE is ignored.
- Requests changing address while not granted: the latest value is sampled at the grant edge.
- stall = (if_req & ~if_valid) | (d_req & ~d_valid), combinational.
- No alignment checking; addresses pass through unmodified.
- Reset mid-access: mem_req drops asynchronously, no valid is generated, and the access is lost. The requester re-issues after reset.

Test Plan:
- Reset: assert rst with mem_req=1 mid-FETCH → mem_req=0 before the next clk edge; after release FSM=IDLE, if_valid=d_valid=0, and a stray mem_ready=1 produces no valid.
- Single fetch: if_req=1, if_addr=0x00000010, mem_ready high 3 cycles after grant with mem_rdata=0x00A00093 → mem_addr=0x10, mem_size=10; if_valid pulses 1 cycle after mem_ready with if_rdata=0x00A00093; stall high from if_req until the if_valid cycle.
- Contention: if_req and d_req (load, d_addr=0x100) asserted together → DATA granted first; d_valid, then one IDLE cycle, then fetch granted; burst_cnt=1 then 0.
- Starvation cap: if_req held, d_req re-asserted after every d_valid, mem_ready immediate, MAX_DATA_BURST=4 → exactly 4 data accesses, then fetch; after the fetch, data is granted again.
- Store halfword: d_we=1, d_size=01, d_addr=0x202, d_wdata=0xBEEF → mem_we=1, mem_size=01, mem_wdata=0xBEEF, mem_addr=0x202; d_valid pulse; d_rdata unchanged.
- Size 11: store with d_size=11 → mem_size=10.
